// File: rtl/axi4_r_arbiter.sv
// axi4_r_arbiter: merges N_PORTS AXI4 R channels into one R channel.
// A burst, once started (or stalled), owns the merged channel until its
// rlast beat completes. Idle arbitration is round-robin, so no source can be
// served twice while another source with a valid beat waits.
// Optional build macro AXI4_R_ARB_FIXED_PRIO_EN: when defined, idle
// arbitration is fixed priority (lowest index wins) and the pointer stays 0.
module axi4_r_arbiter #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int N_PORTS        = 2
) (
  input  logic                                axi4_aclk,
  input  logic                                axi4_arstn,
  input  logic [N_PORTS*AXI_ID_WIDTH-1:0]     m_axi4_rid,
  input  logic [N_PORTS*2-1:0]                m_axi4_rresp,
  input  logic [N_PORTS*AXI_DATA_WIDTH-1:0]   m_axi4_rdata,
  input  logic [N_PORTS-1:0]                  m_axi4_rlast,
  input  logic [N_PORTS*AXI_USER_WIDTH-1:0]   m_axi4_ruser,
  input  logic [N_PORTS-1:0]                  m_axi4_rvalid,
  output logic [N_PORTS-1:0]                  m_axi4_rready,
  output logic [AXI_ID_WIDTH-1:0]             s_axi4_rid,
  output logic [1:0]                          s_axi4_rresp,
  output logic [AXI_DATA_WIDTH-1:0]           s_axi4_rdata,
  output logic                                s_axi4_rlast,
  output logic [AXI_USER_WIDTH-1:0]           s_axi4_ruser,
  output logic                                s_axi4_rvalid,
  input  logic                                s_axi4_rready
);

  localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_r;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   ptr_r;

  logic            win_found_s;
  logic [GW-1:0]   win_idx_s;
  logic [GW-1:0]   sel_s;
  logic            fwd_s;
  logic            valid_s;
  logic            last_s;
  logic [GW-1:0]   data_idx_s;
  logic [GW-1:0]   ptr_nxt_s;

  // Index following idx, wrapping at N_PORTS.
  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
    return (int'(idx) >= (N_PORTS - 1)) ? {GW{1'b0}} : idx + GW'(1);
  endfunction

  // Round-robin search: first valid source starting at ptr_r, wrapping.
  always_comb begin
    logic [GW-1:0] idx;
    logic          hit;
    idx         = '0;
    hit         = 1'b0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx         = GW'((int'(ptr_r) + k) % N_PORTS);
      hit         = m_axi4_rvalid[idx] && !win_found_s;
      win_idx_s   = hit ? idx : win_idx_s;
      win_found_s = win_found_s | m_axi4_rvalid[idx];
    end
  end

  // Choose the forwarded source: the locked owner, else the idle winner.
  always_comb begin
    sel_s = '0;
    fwd_s = 1'b0;
    if (state_r == LOCKED) begin
      sel_s = grant_r;
      fwd_s = 1'b1;
    end else begin
      sel_s = win_idx_s;
      fwd_s = win_found_s;
    end
  end

  // Merged valid/last, data source (source 0 when nothing is presented) and next pointer.
  always_comb begin
    valid_s    = axi4_arstn & fwd_s & m_axi4_rvalid[sel_s];
    last_s     = m_axi4_rlast[sel_s];
    data_idx_s = valid_s ? sel_s : {GW{1'b0}};
`ifdef AXI4_R_ARB_FIXED_PRIO_EN
    ptr_nxt_s  = '0;
`else
    ptr_nxt_s  = next_idx(sel_s);
`endif
  end

  // Zero-latency forwarding of the selected source's R fields.
  always_comb begin
    s_axi4_rvalid = valid_s;
    s_axi4_rid    = m_axi4_rid[data_idx_s*AXI_ID_WIDTH +: AXI_ID_WIDTH];
    s_axi4_rresp  = m_axi4_rresp[data_idx_s*2 +: 2];
    s_axi4_rdata  = m_axi4_rdata[data_idx_s*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    s_axi4_rlast  = m_axi4_rlast[data_idx_s];
    s_axi4_ruser  = m_axi4_ruser[data_idx_s*AXI_USER_WIDTH +: AXI_USER_WIDTH];
  end

  // Ready goes back only to the forwarded source; held low during reset.
  always_comb begin
    m_axi4_rready = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      m_axi4_rready[i] = fwd_s && axi4_arstn && s_axi4_rready && (int'(sel_s) == i);
    end
  end

  // Burst-lock FSM: lock on stall or non-last beat, release on the rlast handshake.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_r <= IDLE;
      grant_r <= '0;
      ptr_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (valid_s) begin
            if (s_axi4_rready && last_s) begin
              state_r <= IDLE;
              ptr_r   <= ptr_nxt_s;
            end else begin
              state_r <= LOCKED;
              grant_r <= sel_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        LOCKED: begin
          if (valid_s && s_axi4_rready && last_s) begin
            state_r <= IDLE;
            ptr_r   <= ptr_nxt_s;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= '0;
          ptr_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_r_arbiter.sv
// Bench for axi4_r_arbiter: a 2-port and a 4-port instance driven by per-source
// beat queues; expected merged beats (with their handshake cycle) are pushed
// to a scoreboard when stimulus is queued and compared on each output handshake.
module tb_axi4_r_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  user;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  beat_t      sq [2][4][$];
  exp_t       eq [2][$];
  logic [3:0] gap [2];
  logic       rdy [2];
  logic [3:0] rv [2];
  beat_t      fr [2][4];
  logic [3:0] hs_mask [2];
  logic [3:0] mrr_seen [2];
  logic       sv_seen [2];
  logic [31:0] sd_seen [2];
  int         cyc;
  int         tests_run;
  int         tests_failed;

  logic [7:0]   rid2;
  logic [3:0]   rresp2;
  logic [63:0]  rdata2;
  logic [1:0]   rlast2;
  logic [7:0]   ruser2;
  logic [1:0]   m_rready2;
  logic [15:0]  rid4;
  logic [7:0]   rresp4;
  logic [127:0] rdata4;
  logic [3:0]   rlast4;
  logic [15:0]  ruser4;
  logic [3:0]   m_rready4;

  logic [3:0]  s_rid [2];
  logic [1:0]  s_rresp [2];
  logic [31:0] s_rdata [2];
  logic        s_rlast [2];
  logic [3:0]  s_ruser [2];
  logic        s_rvalid [2];

  // Pack the front beat of each source onto the DUT input vectors.
  always_comb begin
    rid2 = '0; rresp2 = '0; rdata2 = '0; rlast2 = '0; ruser2 = '0;
    rid4 = '0; rresp4 = '0; rdata4 = '0; rlast4 = '0; ruser4 = '0;
    for (int i = 0; i < 2; i++) begin
      rid2[i*4 +: 4]    = fr[0][i].id;
      rresp2[i*2 +: 2]  = fr[0][i].resp;
      rdata2[i*32 +: 32] = fr[0][i].data;
      rlast2[i]         = fr[0][i].last;
      ruser2[i*4 +: 4]  = fr[0][i].user;
    end
    for (int i = 0; i < 4; i++) begin
      rid4[i*4 +: 4]    = fr[1][i].id;
      rresp4[i*2 +: 2]  = fr[1][i].resp;
      rdata4[i*32 +: 32] = fr[1][i].data;
      rlast4[i]         = fr[1][i].last;
      ruser4[i*4 +: 4]  = fr[1][i].user;
    end
  end

  axi4_r_arbiter #(.AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .N_PORTS(2)) dut2 (
    .axi4_aclk(clk), .axi4_arstn(rst_n),
    .m_axi4_rid(rid2), .m_axi4_rresp(rresp2), .m_axi4_rdata(rdata2),
    .m_axi4_rlast(rlast2), .m_axi4_ruser(ruser2), .m_axi4_rvalid(rv[0][1:0]),
    .m_axi4_rready(m_rready2),
    .s_axi4_rid(s_rid[0]), .s_axi4_rresp(s_rresp[0]), .s_axi4_rdata(s_rdata[0]),
    .s_axi4_rlast(s_rlast[0]), .s_axi4_ruser(s_ruser[0]), .s_axi4_rvalid(s_rvalid[0]),
    .s_axi4_rready(rdy[0])
  );

  axi4_r_arbiter #(.AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4), .N_PORTS(4)) dut4 (
    .axi4_aclk(clk), .axi4_arstn(rst_n),
    .m_axi4_rid(rid4), .m_axi4_rresp(rresp4), .m_axi4_rdata(rdata4),
    .m_axi4_rlast(rlast4), .m_axi4_ruser(ruser4), .m_axi4_rvalid(rv[1]),
    .m_axi4_rready(m_rready4),
    .s_axi4_rid(s_rid[1]), .s_axi4_rresp(s_rresp[1]), .s_axi4_rdata(s_rdata[1]),
    .s_axi4_rlast(s_rlast[1]), .s_axi4_ruser(s_ruser[1]), .s_axi4_rvalid(s_rvalid[1]),
    .s_axi4_rready(rdy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required $finish before 100000");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input int src, input int seq, input logic last);
    beat_t b;
    b.data = 32'hC0DE_0000 | (32'(src) << 8) | 32'(seq);
    b.id   = 4'(src + 5);
    b.resp = 2'(seq);
    b.last = last;
    b.user = 4'(seq + 3 * src);
    return b;
  endfunction

  task automatic push_exp(input int d, input beat_t b, input int c);
    exp_t e;
    e.b   = b;
    e.cyc = c;
    eq[d].push_back(e);
  endtask

  task automatic drive();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (sq[d][i].size() > 0 && !gap[d][i]) begin
          rv[d][i] = 1'b1;
          fr[d][i] = sq[d][i][0];
        end else begin
          rv[d][i] = 1'b0;
          fr[d][i] = '0;
        end
      end
    end
  endtask

  task automatic monitor();
    beat_t got;
    exp_t  e;
    logic [3:0] mrr;
    for (int d = 0; d < 2; d++) begin
      mrr = (d == 0) ? {2'b00, m_rready2} : m_rready4;
      mrr_seen[d] = mrr;
      sv_seen[d]  = s_rvalid[d];
      sd_seen[d]  = s_rdata[d];
      hs_mask[d]  = mrr & rv[d];
      if (s_rvalid[d] && rdy[d]) begin
        got = {s_rdata[d], s_rid[d], s_rresp[d], s_rlast[d], s_ruser[d]};
        tests_run++;
        if (eq[d].size() == 0) begin
          tests_failed++;
          $display("FAIL beat_unexpected dut%0d cyc %0d: got %h, required no beat", d, cyc, got);
        end else begin
          e = eq[d].pop_front();
          if (got !== e.b || cyc != e.cyc) begin
            tests_failed++;
            $display("FAIL beat dut%0d: got %h at cyc %0d, required %h at cyc %0d", d, got, cyc, e.b, e.cyc);
          end
        end
        tests_run++;
        if ($countones(hs_mask[d]) != 1) begin
          tests_failed++;
          $display("FAIL src_handshake dut%0d cyc %0d: got mask %b, required one-hot", d, cyc, hs_mask[d]);
        end
      end
    end
  endtask

  task automatic advance();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (hs_mask[d][i]) void'(sq[d][i].pop_front());
      end
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    advance();
    cyc++;
  endtask

  task automatic drain_check(input int d, input string name);
    tests_run++;
    if (eq[d].size() != 0) begin
      tests_failed++;
      $display("FAIL %s_drain dut%0d: got %0d beats outstanding, required 0", name, d, eq[d].size());
      eq[d].delete();
    end
  endtask

  task automatic clear_sources();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) sq[d][i].delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    for (int i = 0; i < 2; i++) sq[0][i].push_back(mk(i, 1, 1'b1));
    for (int i = 0; i < 4; i++) sq[1][i].push_back(mk(i, 1, 1'b1));
    drive();
    @(negedge clk);
    tests_run++;
    if (s_rvalid[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid2: got %b, required 0", s_rvalid[0]); end
    tests_run++;
    if (m_rready2 !== 2'b00) begin tests_failed++; $display("FAIL reset_rready2: got %b, required 00", m_rready2); end
    tests_run++;
    if (s_rvalid[1] !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid4: got %b, required 0", s_rvalid[1]); end
    tests_run++;
    if (m_rready4 !== 4'h0) begin tests_failed++; $display("FAIL reset_rready4: got %b, required 0000", m_rready4); end
    clear_sources();
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_burst_order();
    cyc = 0;
    rdy[0] = 1'b1;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 4; k++) begin
        sq[0][s].push_back(mk(s, k, k == 3));
        push_exp(0, mk(s, k, k == 3), s * 4 + k);
      end
    end
    repeat (10) tick();
    drain_check(0, "burst_order");
  endtask

  task automatic test_bubble();
    int c;
    cyc = 0;
    rdy[0] = 1'b1;
    for (int k = 0; k < 4; k++) sq[0][0].push_back(mk(0, k + 4, k == 3));
    sq[0][1].push_back(mk(1, 4, 1'b1));
    push_exp(0, mk(0, 4, 1'b0), 0);
    push_exp(0, mk(0, 5, 1'b0), 1);
    push_exp(0, mk(0, 6, 1'b0), 2);
    push_exp(0, mk(0, 7, 1'b1), 6);
    push_exp(0, mk(1, 4, 1'b1), 7);
    while (cyc < 10) begin
      c = cyc;
      gap[0][0] = (c >= 3 && c <= 5);
      tick();
      if (c >= 3 && c <= 5) begin
        tests_run++;
        if (mrr_seen[0][1:0] !== 2'b01) begin
          tests_failed++;
          $display("FAIL bubble_rready cyc %0d: got %b, required 01", c, mrr_seen[0][1:0]);
        end
      end
    end
    gap[0] = 4'h0;
    drain_check(0, "bubble");
  endtask

  task automatic test_stall();
    beat_t a5;
    int c;
    a5.data = 32'hA5A5_A5A5;
    a5.id   = 4'h1;
    a5.resp = 2'b00;
    a5.last = 1'b1;
    a5.user = 4'h3;
    cyc = 0;
    sq[0][1].push_back(a5);
    push_exp(0, a5, 5);
    push_exp(0, mk(0, 9, 1'b1), 6);
    while (cyc < 9) begin
      c = cyc;
      if (c == 2) sq[0][0].push_back(mk(0, 9, 1'b1));
      rdy[0] = (c >= 5);
      tick();
      if (c <= 4) begin
        tests_run++;
        if (sv_seen[0] !== 1'b1 || sd_seen[0] !== 32'hA5A5_A5A5 || mrr_seen[0] !== 4'h0) begin
          tests_failed++;
          $display("FAIL stall_hold cyc %0d: got valid %b data %h rready %b, required 1 a5a5a5a5 0000",
                   c, sv_seen[0], sd_seen[0], mrr_seen[0]);
        end
      end
    end
    drain_check(0, "stall");
  endtask

  task automatic test_reset_mid();
    cyc = 0;
    rdy[0] = 1'b1;
    for (int k = 0; k < 4; k++) sq[0][1].push_back(mk(1, k, k == 3));
    push_exp(0, mk(1, 0, 1'b0), 0);
    push_exp(0, mk(1, 1, 1'b0), 1);
    repeat (2) tick();
    rst_n = 1'b0;
    sq[0][1].delete();
    for (int k = 0; k < 2; k++) begin
      sq[0][0].push_back(mk(0, k + 8, k == 1));
      sq[0][1].push_back(mk(1, k + 8, k == 1));
    end
    drain_check(0, "reset_mid_pre");
    drive();
    @(negedge clk);
    tests_run++;
    if (s_rvalid[0] !== 1'b0 || m_rready2 !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: got valid %b rready %b, required 0 00", s_rvalid[0], m_rready2);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    push_exp(0, mk(0, 8, 1'b0), 0);
    push_exp(0, mk(0, 9, 1'b1), 1);
    push_exp(0, mk(1, 8, 1'b0), 2);
    push_exp(0, mk(1, 9, 1'b1), 3);
    repeat (6) tick();
    drain_check(0, "reset_mid");
  endtask

  task automatic test_rr4();
    cyc = 0;
    rdy[1] = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 6; k++) sq[1][s].push_back(mk(s, k, 1'b1));
    end
    for (int t = 0; t < 24; t++) begin
`ifdef AXI4_R_ARB_FIXED_PRIO_EN
      push_exp(1, mk(t / 6, t % 6, 1'b1), t);
`else
      push_exp(1, mk(t % 4, t / 4, 1'b1), t);
`endif
    end
    repeat (26) tick();
    drain_check(1, "rr4");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    cyc = 0;
    rst_n = 1'b0;
    rdy[0] = 1'b0;
    rdy[1] = 1'b0;
    gap[0] = 4'h0;
    gap[1] = 4'h0;
    hs_mask[0] = 4'h0;
    hs_mask[1] = 4'h0;
    drive();
    #2;
    test_reset();
    test_burst_order();
    test_bubble();
    test_stall();
    test_reset_mid();
    test_rr4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi4_r_arbiter.md
AXI4_R_ARBITER -- requirements
Module: axi4_r_arbiter

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, R data width in bits.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4, R ID width.
REQ-003 SHALL have parameter AXI_USER_WIDTH, default 4, R user width.
REQ-004 SHALL have parameter N_PORTS, default 2, number of R sources; legal range 2..8.
REQ-005 SHALL have port axi4_aclk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port axi4_arstn, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port m_axi4_rid, input, N_PORTS*AXI_ID_WIDTH, per-source ID, source i in slice i.
REQ-008 SHALL have port m_axi4_rresp, input, N_PORTS*2, per-source response.
REQ-009 SHALL have port m_axi4_rdata, input, N_PORTS*AXI_DATA_WIDTH, per-source data.
REQ-010 SHALL have port m_axi4_rlast, input, N_PORTS, per-source last flag.
REQ-011 SHALL have port m_axi4_ruser, input, N_PORTS*AXI_USER_WIDTH, per-source user.
REQ-012 SHALL have port m_axi4_rvalid, input, N_PORTS, per-source valid.
REQ-013 SHALL have port m_axi4_rready, output, N_PORTS, per-source ready.
REQ-014 SHALL have ports s_axi4_rid/rresp/rdata/rlast/ruser/rvalid, outputs, widths as single-source, merged R channel.
REQ-015 SHALL have port s_axi4_rready, input, 1, merged R channel ready.

Function
REQ-016 SHALL implement states IDLE and LOCKED plus a grant register (clog2(N_PORTS) bits) and a round-robin pointer ptr.
REQ-017 In IDLE, SHALL select as winner the first source i with m_axi4_rvalid[i]=1 searching ptr, ptr+1, ... modulo N_PORTS.
REQ-018 In IDLE, SHALL forward the winner's fields combinationally to s_axi4_* in the same cycle (zero latency) and drive s_axi4_rvalid=1; s_axi4_rvalid=0 when no source valid.
REQ-019 In LOCKED, SHALL forward only source grant; s_axi4_rvalid = m_axi4_rvalid[grant].
REQ-020 SHALL drive m_axi4_rready[i] = s_axi4_rready only for the forwarded source, 0 for all others.
REQ-021 IDLE -> LOCKED, grant<=winner, when s_axi4_rvalid=1 and either s_axi4_rready=0 (stall; keeps output stable per AXI) or handshake with rlast=0.
REQ-022 IDLE stays IDLE on handshake with rlast=1; ptr<=winner+1 mod N_PORTS.
REQ-023 LOCKED -> IDLE on handshake of source grant with rlast=1; ptr<=grant+1 mod N_PORTS.
REQ-024 LOCKED SHALL persist through any number of cycles with m_axi4_rvalid[grant]=0 (bubbles inside a burst).
REQ-025 SHALL never interleave beats of different sources between a first beat and its rlast beat.
REQ-026 When s_axi4_rvalid=0, s_axi4_* data fields SHALL be driven from source 0 (don't-care, but deterministic).
REQ-027 Simultaneous valids on all sources SHALL be served one burst each in pointer order before any source is served twice.

Reset
REQ-028 While axi4_arstn=0: state=IDLE, grant=0, ptr=0; s_axi4_rvalid=0 and m_axi4_rready=0 regardless of inputs.
REQ-029 Reset asserted mid-burst SHALL abandon the burst; after release, arbitration restarts from ptr=0.

Configuration
REQ-030 Macro AXI4_R_ARB_FIXED_PRIO_EN: when defined, IDLE winner SHALL be the lowest-index valid source and ptr is held at 0; when undefined, round-robin per REQ-017/022/023.

Verification
REQ-031 N_PORTS=2, src0 and src1 both present 4-beat bursts at cycle 0, rready=1 -> src0 beats cycles 0-3, src1 beats cycles 4-7, no interleave.
REQ-032 src0 burst, beat 2 handshaked, then src0 rvalid=0 for 3 cycles while src1 valid -> m_axi4_rready[1]=0 throughout, src0 beat 3 sent when it returns.
REQ-033 IDLE, src1 valid with rdata=0xA5A5A5A5, rready=0 for 5 cycles, src0 becomes valid at cycle 2 -> output stays src1, rdata=0xA5A5A5A5 until handshake.
REQ-034 N_PORTS=4, all sources continuously issue single-beat (rlast=1) bursts -> grant order 0,1,2,3,0,...; with AXI4_R_ARB_FIXED_PRIO_EN -> source 0 every cycle.
REQ-035 Reset asserted after beat 1 of 4-beat src1 burst -> s_axi4_rvalid=0 during reset; after release with src0 and src1 valid, src0 granted first.
